// File: rtl/multicycle_adder.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per cycle over N = WIDTH/CHUNK cycles,
// with valid/ready handshakes on the operand and result sides.
module multicycle_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] CMASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nxt;
    logic [CW-1:0]    cnt;
    logic             carry_q, cout_q, ovf_q;
    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   csum;
    logic             last;
    int               sh;

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign last     = (cnt == CW'(N - 1));

    // Current chunk slice, its sum, and the running sum with that slice replaced
    always_comb begin
        sh      = int'(cnt) * CHUNK;
        a_ch    = CHUNK'(a_q >> sh);
        b_ch    = CHUNK'(b_q >> sh);
        csum    = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        sum_nxt = (sum_q & ~(CMASK << sh)) | (WIDTH'(csum[CHUNK-1:0]) << sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction stores ~b and an inverted carry so RUN only ever adds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt     <= '0;
        end else if (state == RUN) begin
            sum_q   <= sum_nxt;
            carry_q <= csum[CHUNK];
            cnt     <= cnt + 1'b1;
            if (last) begin
                cout_q <= csum[CHUNK];
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (csum[CHUNK-1] != a_q[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench: directed 8-bit vectors plus an exhaustive 4-bit/1-bit-chunk sweep.
module tb_multicycle_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv8, ir8, ov8, or8, cin8, sub8, co8, of8;
    logic [7:0] a8, b8, s8;
    logic       iv4, ir4, ov4, or4, cin4, sub4, co4, of4;
    logic [3:0] a4, b4, s4;

    multicycle_adder #(.WIDTH(8), .CHUNK(2)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(co8), .overflow(of8));

    multicycle_adder #(.WIDTH(4), .CHUNK(1)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(s4),
        .cout(co4), .overflow(of4));

    typedef struct {logic [7:0] s; logic c; logic o; int acc;} exp_t;
    exp_t q8[$], q4[$];
    int   errors = 0, checks = 0, cyc = 0, hold_left = 0;
    logic seen8 = 1'b0, seen4 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Result monitors: compare every DONE cycle (covers hold stability), latency once
    always @(negedge clk) begin
        if (rst_n && ov8) begin
            chk("excl8", {31'd0, ir8}, 0);
            if (q8.size() == 0) begin
                errors++; checks++;
                $display("FAIL spurious8: result %0h with nothing outstanding", s8);
            end else begin
                if (!seen8) begin chk("lat8", cyc - q8[0].acc, 4); seen8 = 1'b1; end
                chk("res8", {22'd0, s8, co8, of8}, {22'd0, q8[0].s, q8[0].c, q8[0].o});
            end
        end
        if (ov8 && hold_left > 0) begin or8 = 1'b0; hold_left--; end
        else or8 = 1'b1;
        if (ov8 && or8 && q8.size() > 0) begin void'(q8.pop_front()); seen8 = 1'b0; end
    end

    always @(negedge clk) begin
        if (rst_n && ov4) begin
            chk("excl4", {31'd0, ir4}, 0);
            if (q4.size() == 0) begin
                errors++; checks++;
                $display("FAIL spurious4: result %0h with nothing outstanding", s4);
            end else begin
                if (!seen4) begin chk("lat4", cyc - q4[0].acc, 4); seen4 = 1'b1; end
                chk("res4", {26'd0, s4, co4, of4}, {26'd0, q4[0].s[3:0], q4[0].c, q4[0].o});
            end
        end
        or4 = 1'($urandom_range(0, 1));
        if (ov4 && or4 && q4.size() > 0) begin void'(q4.pop_front()); seen4 = 1'b0; end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                       input logic [7:0] es, input logic ec, input logic eo, input bit push);
        int n;
        exp_t e;
        n = 0;
        while (!ir8 && n < 50) begin @(negedge clk); n++; end
        if (!ir8) begin errors++; checks++; $display("FAIL accept8: in_ready stuck low"); return; end
        iv8 = 1'b1; a8 = a; b8 = b; cin8 = ci; sub8 = sb;
        @(posedge clk); @(negedge clk);
        iv8 = 1'b0;
        e.s = es; e.c = ec; e.o = eo; e.acc = cyc;
        if (push) q8.push_back(e);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic sb,
                       input logic [3:0] es, input logic ec, input logic eo);
        int n;
        exp_t e;
        n = 0;
        while (!ir4 && n < 50) begin @(negedge clk); n++; end
        if (!ir4) begin errors++; checks++; $display("FAIL accept4: in_ready stuck low"); return; end
        iv4 = 1'b1; a4 = a; b4 = b; cin4 = ci; sub4 = sb;
        @(posedge clk); @(negedge clk);
        iv4 = 1'b0;
        e.s = {4'd0, es}; e.c = ec; e.o = eo; e.acc = cyc;
        q4.push_back(e);
    endtask

    initial begin
        int n;
        logic [3:0] ta, tb, bb;
        logic       tc, ts, eo;
        logic [4:0] r;
        iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
        iv4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, ir8}, 1);
        chk("rst_out_valid", {31'd0, ov8}, 0);
        chk("rst_outputs", {22'd0, s8, co8, of8}, 0);
        chk("rst4_in_ready", {31'd0, ir4}, 1);
        rst_n = 1'b1;
        @(negedge clk);

        op8(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1);
        op8(8'h7F, 8'h01, 1, 0, 8'h81, 0, 1, 1);
        op8(8'h05, 8'h07, 0, 1, 8'hFE, 0, 0, 1);
        op8(8'h05, 8'h07, 1, 1, 8'hFD, 0, 0, 1);

        // Back-pressure: hold out_ready low 3 DONE cycles while poking the input side
        op8(8'h80, 8'h80, 0, 0, 8'h00, 1, 1, 1);
        hold_left = 3;
        n = 0;
        while (!ov8 && n < 20) begin @(negedge clk); n++; end
        if (!ov8) begin errors++; checks++; $display("FAIL hold_wait: out_valid never rose"); end
        for (int k = 0; k < 4; k++) begin
            chk("hold_in_ready", {31'd0, ir8}, 0);
            iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
        end
        iv8 = 1'b0;
        chk("post_done_in_ready", {31'd0, ir8}, 1);
        chk("post_done_out_valid", {31'd0, ov8}, 0);

        op8(8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, 1);

        // Abort in the 2nd RUN cycle; this operation must produce nothing
        op8(8'h01, 8'h01, 0, 0, 8'h02, 0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, ov8}, 0);
        chk("abort_in_ready", {31'd0, ir8}, 1);
        chk("abort_outputs", {22'd0, s8, co8, of8}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        op8(8'h10, 8'h20, 0, 0, 8'h30, 0, 0, 1);
        op8(8'h10, 8'h10, 0, 1, 8'h00, 1, 0, 1);

        for (int i = 0; i < 1024; i++) begin
            ta = i[3:0]; tb = i[7:4]; tc = i[8]; ts = i[9];
            bb = ts ? ~tb : tb;
            r  = {1'b0, ta} + {1'b0, bb} + {4'd0, ts ^ tc};
            eo = (ta[3] == bb[3]) && (r[3] != ta[3]);
            op4(ta, tb, tc, ts, r[3:0], r[4], eo);
        end

        n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 300) begin @(negedge clk); n++; end
        if (q8.size() != 0 || q4.size() != 0) begin
            errors++; checks++;
            $display("FAIL drain: %0d/%0d results never arrived", q8.size(), q4.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
